// File: rtl/fsm_count_checker_if.sv
// Count-bus bundle between an up-counter (master) and its sequence checker (slave).
interface fsm_count_checker_if #(
  parameter int unsigned WIDTH = 3
);
  logic             en;
  logic [WIDTH-1:0] num;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [WIDTH-1:0] expected;
  logic [7:0]       err_count;

  modport master (
    output en, num,
    input  locked, err, wrap, expected, err_count
  );

  modport slave (
    input  en, num,
    output locked, err, wrap, expected, err_count
  );
endinterface

// File: rtl/fsm_count_checker.sv
// Locks onto a modulo-2^WIDTH up-count sequence and flags skipped, repeated or
// unexpected values once locked.
module fsm_count_checker #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned ERR_LIMIT  = 3
) (
  input logic                clk,
  input logic                reset,
  fsm_count_checker_if.slave bus
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [BadW-1:0]  bad_q, bad_d;
  logic             locked_q, err_q, err_d, wrap_q, wrap_d;
  logic [WIDTH-1:0] expected_q;
  logic [7:0]       err_count_q, err_count_d;

  logic [WIDTH-1:0] step_val;
  logic             step_ok, hold_ok, check_ok;
  logic [GoodW-1:0] good_inc;
  logic [BadW-1:0]  bad_inc;

  assign step_val = prev_q + WIDTH'(1);
  assign step_ok  = (bus.num == step_val);
  assign hold_ok  = (bus.num == prev_q);
  assign check_ok = bus.en ? step_ok : hold_ok;
  assign good_inc = good_q + GoodW'(1);
  assign bad_inc  = bad_q + BadW'(1);

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    bad_d       = bad_q;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    err_count_d = err_count_q;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          prev_d  = bus.num;
          good_d  = '0;
          state_d = StSync;
        end
      end
      StSync: begin
        prev_d = bus.num;
        if (bus.en) begin
          if (step_ok) begin
            if (good_inc == GoodW'(LOCK_COUNT)) begin
              state_d = StLocked;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_inc;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      StLocked: begin
        prev_d = bus.num;
        if (check_ok) begin
          bad_d  = '0;
          wrap_d = bus.en && (bus.num == '0);
        end else begin
          err_d = 1'b1;
          if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
          if (bad_inc == BadW'(ERR_LIMIT)) begin
            state_d = StSync;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      expected_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      locked_q    <= (state_d == StLocked);
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      // Idle expects nothing; otherwise the successor of the value just sampled.
      expected_q  <= (state_d == StIdle) ? '0 : prev_d + WIDTH'(1);
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.wrap      = wrap_q;
  assign bus.expected  = expected_q;
  assign bus.err_count = err_count_q;

endmodule
